reorder_buffer: RTL and testbench

In-order retirement queue for the out-of-order core. At dispatch it allocates ROB indices and drives the renaming interface of the register status table. It accepts out-of-order writebacks, retires entries in program order, and drives the register status release interface at commit. It also forwards completed results to the operand read ports.

---
 rtl/reorder_buffer_pkg.sv | 20 ++
 rtl/rob_entry_array.sv | 100 ++++++++++
 rtl/reorder_buffer.sv | 146 ++++++++++++++
 tb/tb_reorder_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// ==== reorder_buffer_pkg : shared core widths and pointer helpers ====
// ==== rev 1.0                                                       ====
`default_nettype none

package reorder_buffer_pkg;

  localparam int c_NUM_ROB_ENTRY = 6;
  localparam int c_NUM_GPR       = 32;
  localparam int c_DATA_WIDTH    = 32;
  localparam int c_IDXW_ROB      = $clog2(c_NUM_ROB_ENTRY);
  localparam int c_IDXW_REG      = $clog2(c_NUM_GPR);

  // Circular increment for queues whose depth need not be a power of two.
  function automatic int f_wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rob_entry_array.sv
// ==== rob_entry_array : per-entry ROB storage, alloc/writeback/clear ports, comb read ports ====
// ==== rev 1.0                                                                               ====
`default_nettype none

module rob_entry_array
  import reorder_buffer_pkg::*;
#(
  parameter int NUM_ENTRY  = c_NUM_ROB_ENTRY,
  parameter int IDXW       = c_IDXW_ROB,
  parameter int REGW       = c_IDXW_REG,
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int NUM_RD     = 3
)(
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  i_flush,
  input  logic                  i_alloc_valid,
  input  logic [IDXW-1:0]       i_alloc_idx,
  input  logic                  i_alloc_has_dest,
  input  logic [REGW-1:0]       i_alloc_name,
  input  logic                  i_wb_valid,
  input  logic [IDXW-1:0]       i_wb_idx,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic                  i_clr_valid,
  input  logic [IDXW-1:0]       i_clr_idx,
  input  logic [IDXW-1:0]       i_rd_idx  [NUM_RD],
  output logic                  o_rd_busy [NUM_RD],
  output logic                  o_rd_done [NUM_RD],
  output logic [DATA_WIDTH-1:0] o_rd_data [NUM_RD],
  output logic                  o_head_has_dest,
  output logic [REGW-1:0]       o_head_name
);

  logic                  r_busy     [NUM_ENTRY];
  logic                  r_done     [NUM_ENTRY];
  logic                  r_has_dest [NUM_ENTRY];
  logic [REGW-1:0]       r_name     [NUM_ENTRY];
  logic [DATA_WIDTH-1:0] r_data     [NUM_ENTRY];

  function automatic logic f_in_range(input logic [IDXW-1:0] idx);
    return 32'(idx) < NUM_ENTRY;
  endfunction

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        r_busy[i]     <= 1'b0;
        r_done[i]     <= 1'b0;
        r_has_dest[i] <= 1'b0;
        r_name[i]     <= '0;
        r_data[i]     <= '0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        r_busy[i] <= 1'b0;
        r_done[i] <= 1'b0;
      end
    end else begin
      if (i_alloc_valid && f_in_range(i_alloc_idx)) begin
        r_busy[i_alloc_idx]     <= 1'b1;
        r_done[i_alloc_idx]     <= 1'b0;
        r_has_dest[i_alloc_idx] <= i_alloc_has_dest;
        r_name[i_alloc_idx]     <= i_alloc_name;
      end
      // Reads pre-edge flags, so an entry allocated this cycle or already done drops the writeback.
      if (i_wb_valid && f_in_range(i_wb_idx)) begin
        if (r_busy[i_wb_idx] && !r_done[i_wb_idx]) begin
          r_done[i_wb_idx] <= 1'b1;
          r_data[i_wb_idx] <= i_wb_data;
        end
      end
      if (i_clr_valid && f_in_range(i_clr_idx)) begin
        r_busy[i_clr_idx] <= 1'b0;
        r_done[i_clr_idx] <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      o_rd_busy[p] = 1'b0;
      o_rd_done[p] = 1'b0;
      o_rd_data[p] = '0;
      if (f_in_range(i_rd_idx[p])) begin
        o_rd_busy[p] = r_busy[i_rd_idx[p]];
        o_rd_done[p] = r_done[i_rd_idx[p]];
        o_rd_data[p] = r_data[i_rd_idx[p]];
      end
    end
    o_head_has_dest = 1'b0;
    o_head_name     = '0;
    if (f_in_range(i_rd_idx[NUM_RD-1])) begin
      o_head_has_dest = r_has_dest[i_rd_idx[NUM_RD-1]];
      o_head_name     = r_name[i_rd_idx[NUM_RD-1]];
    end
  end

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ==== reorder_buffer : in-order retirement queue with rename, release and result forwarding ====
// ==== rev 1.0                                                                               ====
`default_nettype none

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter  int NUM_ROB_ENTRY                = c_NUM_ROB_ENTRY,
  parameter  int NUM_GENERAL_PURPOSE_REGISTER = c_NUM_GPR,
  parameter  int DATA_WIDTH                   = c_DATA_WIDTH,
  parameter  int NUM_READ_PORT                = 2,
  localparam int IDXW_ROB                     = $clog2(NUM_ROB_ENTRY),
  localparam int IDXW_REG                     = $clog2(NUM_GENERAL_PURPOSE_REGISTER)
)(
  input  logic                              clk_in,
  input  logic                              reset_in,
  input  logic                              flush_in,
  input  logic                              dispatch_valid_in,
  output logic                              dispatch_ready_out,
  input  logic                              dispatch_has_dest_in,
  input  logic [IDXW_REG-1:0]               dispatch_dest_name_in,
  output logic [IDXW_ROB-1:0]               dispatch_rob_index_out,
  output logic                              renaming_valid_out,
  output logic [IDXW_REG-1:0]               renaming_name_out,
  output logic [IDXW_ROB-1:0]               renaming_rob_index_out,
  input  logic                              writeback_valid_in,
  input  logic [IDXW_ROB-1:0]               writeback_rob_index_in,
  input  logic [DATA_WIDTH-1:0]             writeback_data_in,
  output logic                              commit_valid_out,
  input  logic                              commit_ready_in,
  output logic                              commit_has_dest_out,
  output logic [IDXW_REG-1:0]               commit_name_out,
  output logic [DATA_WIDTH-1:0]             commit_data_out,
  output logic                              release_valid_out,
  output logic [IDXW_REG-1:0]               release_name_out,
  output logic [IDXW_ROB-1:0]               release_rob_index_out,
  input  logic [NUM_READ_PORT*IDXW_ROB-1:0] read_rob_index_flatted_in,
  output logic [NUM_READ_PORT-1:0]          read_ready_flatted_out,
  output logic [NUM_READ_PORT*DATA_WIDTH-1:0] read_data_flatted_out
);

  localparam int CNTW = $clog2(NUM_ROB_ENTRY + 1);

  logic [IDXW_ROB-1:0]   r_head;
  logic [IDXW_ROB-1:0]   r_tail;
  logic [CNTW-1:0]       r_count;

  logic                  w_dispatch_fire;
  logic                  w_commit_fire;
  logic [IDXW_ROB-1:0]   w_rd_idx  [NUM_READ_PORT+1];
  logic                  w_rd_busy [NUM_READ_PORT+1];
  logic                  w_rd_done [NUM_READ_PORT+1];
  logic [DATA_WIDTH-1:0] w_rd_data [NUM_READ_PORT+1];
  logic                  w_head_has_dest;
  logic [IDXW_REG-1:0]   w_head_name;

  // Occupancy comes from the registered count only; same-cycle commits do not open a slot.
  assign dispatch_ready_out     = reset_in && (r_count != CNTW'(NUM_ROB_ENTRY)) && !flush_in;
  assign w_dispatch_fire        = dispatch_valid_in && dispatch_ready_out;
  assign dispatch_rob_index_out = r_tail;

  assign renaming_valid_out     = w_dispatch_fire && dispatch_has_dest_in;
  assign renaming_name_out      = renaming_valid_out ? dispatch_dest_name_in : '0;
  assign renaming_rob_index_out = renaming_valid_out ? r_tail : '0;

  assign commit_valid_out    = w_rd_busy[NUM_READ_PORT] && w_rd_done[NUM_READ_PORT] && !flush_in;
  assign w_commit_fire       = commit_valid_out && commit_ready_in;
  assign commit_has_dest_out = commit_valid_out && w_head_has_dest;
  assign commit_name_out     = commit_valid_out ? w_head_name : '0;
  assign commit_data_out     = commit_valid_out ? w_rd_data[NUM_READ_PORT] : '0;

  assign release_valid_out     = w_commit_fire && w_head_has_dest;
  assign release_name_out      = release_valid_out ? w_head_name : '0;
  assign release_rob_index_out = release_valid_out ? r_head : '0;

  always_comb begin
    for (int p = 0; p < NUM_READ_PORT; p++) begin
      w_rd_idx[p] = read_rob_index_flatted_in[p*IDXW_ROB +: IDXW_ROB];
    end
    w_rd_idx[NUM_READ_PORT] = r_head;
  end

  always_comb begin
    read_ready_flatted_out = '0;
    read_data_flatted_out  = '0;
    for (int p = 0; p < NUM_READ_PORT; p++) begin
      if (reset_in && writeback_valid_in && (writeback_rob_index_in == w_rd_idx[p])) begin
        read_ready_flatted_out[p]                       = 1'b1;
        read_data_flatted_out[p*DATA_WIDTH +: DATA_WIDTH] = writeback_data_in;
      end else if (w_rd_busy[p] && w_rd_done[p]) begin
        read_ready_flatted_out[p]                       = 1'b1;
        read_data_flatted_out[p*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[p];
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_dispatch_fire) r_tail <= IDXW_ROB'(f_wrap_inc(32'(r_tail), NUM_ROB_ENTRY));
      if (w_commit_fire)   r_head <= IDXW_ROB'(f_wrap_inc(32'(r_head), NUM_ROB_ENTRY));
      unique case ({w_dispatch_fire, w_commit_fire})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  rob_entry_array #(
    .NUM_ENTRY  (NUM_ROB_ENTRY),
    .IDXW       (IDXW_ROB),
    .REGW       (IDXW_REG),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_RD     (NUM_READ_PORT + 1)
  ) u_entries (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .i_flush          (flush_in),
    .i_alloc_valid    (w_dispatch_fire),
    .i_alloc_idx      (r_tail),
    .i_alloc_has_dest (dispatch_has_dest_in),
    .i_alloc_name     (dispatch_dest_name_in),
    .i_wb_valid       (writeback_valid_in),
    .i_wb_idx         (writeback_rob_index_in),
    .i_wb_data        (writeback_data_in),
    .i_clr_valid      (w_commit_fire),
    .i_clr_idx        (r_head),
    .i_rd_idx         (w_rd_idx),
    .o_rd_busy        (w_rd_busy),
    .o_rd_done        (w_rd_done),
    .o_rd_data        (w_rd_data),
    .o_head_has_dest  (w_head_has_dest),
    .o_head_name      (w_head_name)
  );

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ==== tb_reorder_buffer : scoreboard bench for reorder_buffer ====
// ==== rev 1.0                                                  ====
`default_nettype none

module tb_reorder_buffer;

  localparam int N   = 6;
  localparam int DW  = 32;
  localparam int NRP = 2;

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic            flush_in;
  logic            dispatch_valid_in;
  logic            dispatch_ready_out;
  logic            dispatch_has_dest_in;
  logic [4:0]      dispatch_dest_name_in;
  logic [2:0]      dispatch_rob_index_out;
  logic            renaming_valid_out;
  logic [4:0]      renaming_name_out;
  logic [2:0]      renaming_rob_index_out;
  logic            writeback_valid_in;
  logic [2:0]      writeback_rob_index_in;
  logic [DW-1:0]   writeback_data_in;
  logic            commit_valid_out;
  logic            commit_ready_in;
  logic            commit_has_dest_out;
  logic [4:0]      commit_name_out;
  logic [DW-1:0]   commit_data_out;
  logic            release_valid_out;
  logic [4:0]      release_name_out;
  logic [2:0]      release_rob_index_out;
  logic [NRP*3-1:0]  read_rob_index_flatted_in;
  logic [NRP-1:0]    read_ready_flatted_out;
  logic [NRP*DW-1:0] read_data_flatted_out;

  always #5 clk_in = ~clk_in;

  reorder_buffer #(
    .NUM_ROB_ENTRY                (N),
    .NUM_GENERAL_PURPOSE_REGISTER (32),
    .DATA_WIDTH                   (DW),
    .NUM_READ_PORT                (NRP)
  ) u_dut (
    .clk_in                    (clk_in),
    .reset_in                  (reset_in),
    .flush_in                  (flush_in),
    .dispatch_valid_in         (dispatch_valid_in),
    .dispatch_ready_out        (dispatch_ready_out),
    .dispatch_has_dest_in      (dispatch_has_dest_in),
    .dispatch_dest_name_in     (dispatch_dest_name_in),
    .dispatch_rob_index_out    (dispatch_rob_index_out),
    .renaming_valid_out        (renaming_valid_out),
    .renaming_name_out         (renaming_name_out),
    .renaming_rob_index_out    (renaming_rob_index_out),
    .writeback_valid_in        (writeback_valid_in),
    .writeback_rob_index_in    (writeback_rob_index_in),
    .writeback_data_in         (writeback_data_in),
    .commit_valid_out          (commit_valid_out),
    .commit_ready_in           (commit_ready_in),
    .commit_has_dest_out       (commit_has_dest_out),
    .commit_name_out           (commit_name_out),
    .commit_data_out           (commit_data_out),
    .release_valid_out         (release_valid_out),
    .release_name_out          (release_name_out),
    .release_rob_index_out     (release_rob_index_out),
    .read_rob_index_flatted_in (read_rob_index_flatted_in),
    .read_ready_flatted_out    (read_ready_flatted_out),
    .read_data_flatted_out     (read_data_flatted_out)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: program-order queue of live entries plus per-index completion state.
  typedef struct {
    logic [2:0] idx;
    bit         hd;
    logic [4:0] nm;
  } ent_t;

  ent_t        q[$];
  bit          m_busy [N];
  bit          m_done [N];
  logic [31:0] m_data [N];
  int          m_tail;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0;
      m_done[i] = 0;
      m_data[i] = '0;
    end
    m_tail = 0;
  endtask

  task automatic cyc(input bit disp, input bit hd, input logic [4:0] nm,
                     input bit wb, input logic [2:0] wi, input logic [31:0] wd,
                     input bit cr, input bit fl, input logic [2:0] r0, input logic [2:0] r1);
    bit          exp_rdy, dfire, exp_cv, cfire, wb_ok, e_rr;
    logic [31:0] e_rd;
    logic [2:0]  rd [NRP];
    ent_t        h;
    dispatch_valid_in         = disp;
    dispatch_has_dest_in      = hd;
    dispatch_dest_name_in     = nm;
    writeback_valid_in        = wb;
    writeback_rob_index_in    = wi;
    writeback_data_in         = wd;
    commit_ready_in           = cr;
    flush_in                  = fl;
    read_rob_index_flatted_in = {r1, r0};
    rd[0] = r0;
    rd[1] = r1;
    #1;
    exp_rdy = (q.size() != N) && !fl;
    dfire   = disp && exp_rdy;
    chk_eq("dispatch_ready", dispatch_ready_out, exp_rdy);
    chk_eq("dispatch_idx", dispatch_rob_index_out, m_tail);
    chk_eq("rename_valid", renaming_valid_out, dfire && hd);
    if (dfire && hd) begin
      chk_eq("rename_name", renaming_name_out, nm);
      chk_eq("rename_idx", renaming_rob_index_out, m_tail);
    end
    h = '{idx: 3'd0, hd: 1'b0, nm: 5'd0};
    if (q.size() != 0) h = q[0];
    exp_cv = !fl && (q.size() != 0) && m_done[h.idx];
    cfire  = exp_cv && cr;
    chk_eq("commit_valid", commit_valid_out, exp_cv);
    if (exp_cv) begin
      chk_eq("commit_has_dest", commit_has_dest_out, h.hd);
      chk_eq("commit_name", commit_name_out, h.nm);
      chk_eq("commit_data", commit_data_out, m_data[h.idx]);
    end
    chk_eq("release_valid", release_valid_out, cfire && h.hd);
    if (cfire && h.hd) begin
      chk_eq("release_idx", release_rob_index_out, h.idx);
      chk_eq("release_name", release_name_out, h.nm);
    end
    for (int p = 0; p < NRP; p++) begin
      e_rr = 0;
      e_rd = '0;
      if (wb && wi == rd[p]) begin
        e_rr = 1;
        e_rd = wd;
      end else if (rd[p] < N) begin
        if (m_busy[rd[p]] && m_done[rd[p]]) begin
          e_rr = 1;
          e_rd = m_data[rd[p]];
        end
      end
      chk_eq($sformatf("rd%0d_ready", p), read_ready_flatted_out[p], e_rr);
      chk_eq($sformatf("rd%0d_data", p), read_data_flatted_out[p*DW +: DW], e_rd);
    end
    wb_ok = 0;
    if (wb && !fl && wi < N) wb_ok = m_busy[wi] && !m_done[wi];
    @(posedge clk_in);
    #1;
    if (fl) begin
      model_reset();
    end else begin
      if (cfire) begin
        m_busy[h.idx] = 0;
        m_done[h.idx] = 0;
        void'(q.pop_front());
      end
      if (wb_ok) begin
        m_done[wi] = 1;
        m_data[wi] = wd;
      end
      if (dfire) begin
        q.push_back('{idx: 3'(m_tail), hd: hd, nm: nm});
        m_busy[m_tail] = 1;
        m_done[m_tail] = 0;
        m_tail = (m_tail == N - 1) ? 0 : m_tail + 1;
      end
    end
    dispatch_valid_in  = 0;
    writeback_valid_in = 0;
    commit_ready_in    = 0;
    flush_in           = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         seq [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
    logic [2:0] prev;
    reset_in = 0; flush_in = 0; dispatch_valid_in = 0; dispatch_has_dest_in = 0;
    dispatch_dest_name_in = '0; writeback_valid_in = 0; writeback_rob_index_in = '0;
    writeback_data_in = '0; commit_ready_in = 0; read_rob_index_flatted_in = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk_eq("rst_dispatch_ready", dispatch_ready_out, 0);
    chk_eq("rst_commit_valid", commit_valid_out, 0);
    chk_eq("rst_dispatch_idx", dispatch_rob_index_out, 0);
    chk_eq("rst_read_ready", read_ready_flatted_out, 0);
    reset_in = 1;
    #1;
    chk_eq("post_rst_ready", dispatch_ready_out, 1);

    // First dispatch: reg 5 renamed to index 0.
    cyc(1, 1, 5'd5, 0, 0, 0, 0, 0, 3'd0, 3'd1);
    #1;
    chk_eq("t1_next_idx", dispatch_rob_index_out, 1);
    chk_eq("t1_commit_valid", commit_valid_out, 0);

    // Fill to six entries without commit, then offer one more.
    for (int i = 1; i < N; i++) cyc(1, (i % 2) == 0, 5'(5 + i), 0, 0, 0, 0, 0, 3'd0, 3'd1);
    cyc(1, 1, 5'd20, 0, 0, 0, 0, 0, 3'd0, 3'd1);

    // Out-of-order completion 2,0,1; dispatch offered in the first commit cycle.
    cyc(0, 0, 0, 1, 3'd2, 32'h2222, 1, 0, 3'd2, 3'd0);
    cyc(0, 0, 0, 1, 3'd0, 32'h1000, 1, 0, 3'd0, 3'd2);
    cyc(1, 1, 5'd21, 1, 3'd1, 32'h1111, 1, 0, 3'd1, 3'd0);
    for (int i = 3; i < N; i++) cyc(0, 0, 0, 1, 3'(i), 32'h3000 + i, 1, 0, 3'(i), 3'd2);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, 0, 3'd5, 3'd4);

    // Wrap: eight instructions streaming through the six-entry ring.
    prev = '0;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) chk_eq("wrap_idx", dispatch_rob_index_out, seq[i]);
      cyc(i < 8, 1, 5'(i + 1), i > 0, prev, 32'h4000 + i, 1, 0, prev, 3'd7);
      if (i < 8) prev = 3'(seq[i]);
    end
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 3'd1);

    // Forwarding on idx 3, then a duplicate writeback that must not stick.
    for (int i = 0; i < 4; i++) cyc(1, 1, 5'(10 + i), 0, 0, 0, 0, 0, 3'd3, 3'd2);
    cyc(0, 0, 0, 1, 3'd3, 32'hDEAD, 0, 0, 3'd3, 3'd2);
    cyc(0, 0, 0, 1, 3'd3, 32'hBEEF, 0, 0, 3'd3, 3'd4);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 3'd3, 3'd4);

    // Flush with four live entries while a dispatch and a commit are offered.
    cyc(0, 0, 0, 1, 3'd2, 32'h5A5A, 0, 0, 3'd2, 3'd3);
    cyc(1, 1, 5'd9, 0, 0, 0, 1, 1, 3'd2, 3'd3);
    #1;
    chk_eq("flush_idx", dispatch_rob_index_out, 0);
    chk_eq("flush_commit_valid", commit_valid_out, 0);
    chk_eq("flush_ready", dispatch_ready_out, 1);
    for (int i = 0; i <= N; i++) cyc(1, 1, 5'(i + 1), 0, 0, 0, 0, 0, 3'd0, 3'd1);

    // Asynchronous reset mid-operation.
    cyc(0, 0, 0, 1, 3'd0, 32'h7777, 0, 0, 3'd0, 3'd1);
    read_rob_index_flatted_in = {3'd1, 3'd0};
    #1;
    chk_eq("pre_rst_commit_valid", commit_valid_out, 1);
    chk_eq("pre_rst_read_ready", read_ready_flatted_out, 2'b01);
    #2;
    reset_in = 0;
    #1;
    chk_eq("arst_commit_valid", commit_valid_out, 0);
    chk_eq("arst_commit_data", commit_data_out, 0);
    chk_eq("arst_dispatch_ready", dispatch_ready_out, 0);
    chk_eq("arst_dispatch_idx", dispatch_rob_index_out, 0);
    chk_eq("arst_read_ready", read_ready_flatted_out, 0);
    chk_eq("arst_read_data", read_data_flatted_out, 0);
    @(posedge clk_in);
    #1;
    reset_in = 1;
    model_reset();
    cyc(1, 1, 5'd3, 0, 0, 0, 0, 0, 3'd0, 3'd1);
    cyc(0, 0, 0, 1, 3'd0, 32'hCAFE, 1, 0, 3'd0, 3'd1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 3'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
